scoreboard_register_file: RTL and testbench

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

---
 rtl/scoreboard_register_file.sv | 114 +++++++++++
 tb/tb_scoreboard_register_file.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_register_file.sv
// Register file with a per-register busy scoreboard and same-cycle write forwarding.
// Two combinational read ports, one write port, one issue port, registered pending count.

module scoreboard_rf_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            busy_bit,
  input  logic            write_enable,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_din,
  output logic [XLEN-1:0] dout,
  output logic            busy
);
  logic hit;

  // A writeback landing this cycle both supplies the data and retires the producer.
  assign hit  = (BYPASS != 0) && write_enable && (rd == rs) && (rs != '0);
  assign dout = (rs == '0) ? '0 : (hit ? rd_din : rf_val);
  assign busy = hit ? 1'b0 : busy_bit;
endmodule

module scoreboard_register_file #(
  parameter int                XLEN    = 32,
  parameter int                NREGS   = 32,
  parameter logic [XLEN-1:0]   SP_INIT = 32'h2ffc,
  parameter int                BYPASS  = 1,
  localparam int               AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_dout,
  output logic [XLEN-1:0] rs2_dout,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_din,
  input  logic            write_enable,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic [AW:0]     pending_cnt,
  output logic [XLEN-1:0] x17_val
);
  localparam int NPORTS = 2;
  localparam int CW     = AW + 1;

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  logic             wb_eff, iss_eff, cnt_inc, cnt_dec;

  logic [NPORTS-1:0][AW-1:0]   rs_v;
  logic [NPORTS-1:0][XLEN-1:0] rf_rd, dout_v;
  logic [NPORTS-1:0]           busy_rd, busy_v;

  assign wb_eff  = write_enable && (rd != '0);
  assign iss_eff = issue_valid && (issue_rd != '0);

  // Issue wins over a same-register writeback: the new producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wb_eff)  busy_nxt[rd]       = 1'b0;
    if (iss_eff) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign cnt_inc = iss_eff && !busy[issue_rd];
  assign cnt_dec = wb_eff && busy[rd] && !(iss_eff && (issue_rd == rd));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= (i == 2) ? SP_INIT : '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (wb_eff) rf[rd] <= rd_din;
      busy        <= busy_nxt;
      pending_cnt <= pending_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  assign rs_v = {rs2, rs1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign rf_rd[p]   = rf[rs_v[p]];
    assign busy_rd[p] = busy[rs_v[p]];
    scoreboard_rf_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .rs           (rs_v[p]),
      .rf_val       (rf_rd[p]),
      .busy_bit     (busy_rd[p]),
      .write_enable (write_enable),
      .rd           (rd),
      .rd_din       (rd_din),
      .dout         (dout_v[p]),
      .busy         (busy_v[p])
    );
  end

  assign rs1_dout = dout_v[0];
  assign rs2_dout = dout_v[1];
  assign rs1_busy = busy_v[0];
  assign rs2_busy = busy_v[1];

  // Architectural value only; never forwarded.
  if (NREGS > 17) begin : g_x17
    assign x17_val = rf[17];
  end else begin : g_no_x17
    assign x17_val = '0;
  end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file with default parameters.
module tb_scoreboard_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic [31:0] rs1_dout, rs2_dout, rd_din, x17_val;
  logic        rs1_busy, rs2_busy, write_enable, issue_valid;
  logic [5:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;

  scoreboard_register_file dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .pending_cnt(pending_cnt), .x17_val(x17_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 0; issue_valid = 0; rd = 0; issue_rd = 0; rd_din = 0;
  endtask

  initial begin
    reset = 1; rs1 = 0; rs2 = 0;
    idle();
    step();
    reset = 0;
    #1;

    // reset state
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(r);
      #1;
      chk("rst_rs1_dout", rs1_dout, (r == 2) ? 32'h2ffc : 32'h0);
      chk("rst_rs2_busy", 32'(rs2_busy), 32'h0);
    end
    chk("rst_pending", 32'(pending_cnt), 32'd0);
    chk("rst_x17", x17_val, 32'h0);

    // write / read, and writes to x0 ignored
    rd = 5; rd_din = 32'hDEADBEEF; write_enable = 1;
    step();
    idle(); rs1 = 5;
    #1;
    chk("wr5_rd", rs1_dout, 32'hDEADBEEF);
    rd = 0; rd_din = 32'h1234; write_enable = 1; rs2 = 0;
    #1;
    chk("wr0_byp", rs2_dout, 32'h0);
    step();
    idle();
    #1;
    chk("wr0_rd", rs2_dout, 32'h0);
    chk("wr0_cnt", 32'(pending_cnt), 32'd0);

    // bypass with busy target
    issue_valid = 1; issue_rd = 7;
    step();
    idle(); rs1 = 7;
    #1;
    chk("iss7_busy", 32'(rs1_busy), 32'd1);
    chk("iss7_cnt", 32'(pending_cnt), 32'd1);
    write_enable = 1; rd = 7; rd_din = 32'hA5A5A5A5;
    #1;
    chk("byp_dout", rs1_dout, 32'hA5A5A5A5);
    chk("byp_busy", 32'(rs1_busy), 32'd0);
    step();
    idle();
    #1;
    chk("wb7_dout", rs1_dout, 32'hA5A5A5A5);
    chk("wb7_busy", 32'(rs1_busy), 32'd0);
    chk("wb7_cnt", 32'(pending_cnt), 32'd0);

    // x17 is not forwarded
    write_enable = 1; rd = 17; rd_din = 32'h1717;
    #1;
    chk("x17_pre", x17_val, 32'h0);
    step();
    idle();
    #1;
    chk("x17_post", x17_val, 32'h1717);

    // scoreboard: issue wins over same-register writeback
    issue_valid = 1; issue_rd = 3; rs1 = 3;
    step();
    chk("sb_busy1", 32'(rs1_busy), 32'd1);
    chk("sb_cnt1", 32'(pending_cnt), 32'd1);
    write_enable = 1; rd = 3; rd_din = 32'h33;
    step();
    idle();
    #1;
    chk("sb_busy2", 32'(rs1_busy), 32'd1);
    chk("sb_cnt2", 32'(pending_cnt), 32'd1);
    chk("sb_data2", rs1_dout, 32'h33);
    write_enable = 1; rd = 3; rd_din = 32'h34;
    step();
    idle();
    #1;
    chk("sb_busy3", 32'(rs1_busy), 32'd0);
    chk("sb_cnt3", 32'(pending_cnt), 32'd0);
    chk("sb_data3", rs1_dout, 32'h34);

    // counter: fill all, issue x0, net-zero update
    for (int r = 1; r < 32; r++) begin
      issue_valid = 1; issue_rd = 5'(r);
      step();
    end
    idle();
    #1;
    chk("cnt_full", 32'(pending_cnt), 32'd31);
    issue_valid = 1; issue_rd = 0;
    step();
    idle();
    #1;
    chk("cnt_iss0", 32'(pending_cnt), 32'd31);
    issue_valid = 1; issue_rd = 9;
    step();
    idle();
    #1;
    chk("cnt_reiss", 32'(pending_cnt), 32'd31);
    write_enable = 1; rd = 4; rd_din = 32'h44;
    step();
    idle();
    #1;
    chk("cnt_wb4", 32'(pending_cnt), 32'd30);
    issue_valid = 1; issue_rd = 4; write_enable = 1; rd = 9; rd_din = 32'h99;
    step();
    idle(); rs1 = 4; rs2 = 9;
    #1;
    chk("cnt_net0", 32'(pending_cnt), 32'd30);
    chk("cnt_busy4", 32'(rs1_busy), 32'd1);
    chk("cnt_busy9", 32'(rs2_busy), 32'd0);
    chk("cnt_data9", rs2_dout, 32'h99);
    write_enable = 1; rd = 20; rd_din = 32'h20;
    step();
    idle();
    #1;
    chk("cnt_wb_idle", 32'(pending_cnt), 32'd29);

    // reset mid-operation with 5 busy registers
    reset = 1;
    step();
    reset = 0;
    for (int r = 1; r <= 5; r++) begin
      issue_valid = 1; issue_rd = 5'(r);
      write_enable = (r == 1); rd = 17; rd_din = 32'hCAFE;
      step();
    end
    idle();
    #1;
    chk("mid_cnt5", 32'(pending_cnt), 32'd5);
    chk("mid_x17", x17_val, 32'hCAFE);
    reset = 1; write_enable = 1; rd = 6; rd_din = 32'h66; issue_valid = 1; issue_rd = 8;
    step();
    reset = 0;
    idle(); rs1 = 2; rs2 = 6;
    #1;
    chk("mr_cnt", 32'(pending_cnt), 32'd0);
    chk("mr_x17", x17_val, 32'h0);
    chk("mr_sp", rs1_dout, 32'h2ffc);
    chk("mr_wr_ign", rs2_dout, 32'h0);
    rs1 = 8; rs2 = 3;
    #1;
    chk("mr_iss_ign", 32'(rs1_busy), 32'd0);
    chk("mr_busy3", 32'(rs2_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
